uart_baud_gen: RTL and testbench

Parametrised UART baud-rate generator for 8 runtime-selectable rates (9600 to 921600). It derives divisors at elaboration from CLK_HZ. It provides two independent channels:
- RX channel: mid-bit strobe plus a 16x oversample tick.
- TX channel: end-of-bit tick.

It sits between the host config register and the uart_rx/uart_tx datapaths.

---
 rtl/uart_baud_pkg.sv | 34 +++
 rtl/uart_baud_chan.sv | 37 +++
 rtl/uart_baud_gen.sv | 103 ++++++++++
 tb/tb_uart_baud_gen.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_baud_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_baud_pkg : rate table and divisor helpers for uart_baud_gen          |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
package uart_baud_pkg;

    localparam int SEL_W     = 3;
    localparam int NUM_RATES = 1 << SEL_W;

    localparam int BAUD_TABLE [NUM_RATES] = '{
        9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600
    };

    // Rounded clocks-per-bit minus one; floored at 0 so a too-slow clock still
    // yields a legal one-cycle period.
    function automatic int div_of(input int clk_hz, input int baud);
        int q;
        q = (clk_hz + baud / 2) / baud;
        return (q > 0) ? q - 1 : 0;
    endfunction

    function automatic int half_of(input int div);
        return div >> 1;
    endfunction

    function automatic int odiv_of(input int div, input int ovs);
        int q;
        q = (div + 1) / ovs;
        return (q > 0) ? q - 1 : 0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_chan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_baud_chan : enable-gated wrap counter with registered compare pulse  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module uart_baud_chan #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] div,
    input  logic [CNT_W-1:0] cmp,
    output logic             pulse,
    output logic             wrap
);

    logic [CNT_W-1:0] cnt;

    assign wrap = en && (cnt == div);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            pulse <= en && (cnt == cmp);
            if (!en || wrap) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_baud_gen : 8-rate UART baud generator, RX mid-bit/oversample + TX    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module uart_baud_gen
    import uart_baud_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int CNT_W  = 16,
    parameter int OVS    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SEL_W-1:0] baud_sel,
    input  logic             rx_en,
    input  logic             tx_en,
    output logic             rx_mid,
    output logic             ovs_tick,
    output logic             tx_tick,
    output logic [SEL_W-1:0] active_sel,
    output logic             busy,
    output logic             cfg_err
);

    logic [CNT_W-1:0]     div_tab  [NUM_RATES];
    logic [CNT_W-1:0]     half_tab [NUM_RATES];
    logic [CNT_W-1:0]     odiv_tab [NUM_RATES];
    logic [NUM_RATES-1:0] err_tab;

    for (genvar k = 0; k < NUM_RATES; k++) begin : g_tab
        localparam int DIV_K = div_of(CLK_HZ, BAUD_TABLE[k]);
        assign div_tab[k]  = CNT_W'(DIV_K);
        assign half_tab[k] = CNT_W'(half_of(DIV_K));
        assign odiv_tab[k] = CNT_W'(odiv_of(DIV_K, OVS));
        assign err_tab[k]  = (DIV_K + 1) < OVS;
    end

    logic             idle;
    logic [SEL_W-1:0] sel_next;
    logic [CNT_W-1:0] div_sel;
    logic [CNT_W-1:0] half_sel;
    logic [CNT_W-1:0] odiv_sel;
    logic             rx_wrap;
    logic             tx_wrap_unused;
    logic [CNT_W-1:0] ovs_cnt;

    // Rate changes are only accepted while both channels are idle.
    assign idle     = !rx_en && !tx_en;
    assign sel_next = idle ? baud_sel : active_sel;
    assign div_sel  = div_tab[active_sel];
    assign half_sel = half_tab[active_sel];
    assign odiv_sel = odiv_tab[active_sel];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_sel <= '0;
            cfg_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            active_sel <= sel_next;
            cfg_err    <= err_tab[sel_next];
            busy       <= rx_en | tx_en;
        end
    end

    uart_baud_chan #(.CNT_W(CNT_W)) u_rx_chan (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (rx_en),
        .div   (div_sel),
        .cmp   (half_sel),
        .pulse (rx_mid),
        .wrap  (rx_wrap)
    );

    uart_baud_chan #(.CNT_W(CNT_W)) u_tx_chan (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (tx_en),
        .div   (div_sel),
        .cmp   (div_sel),
        .pulse (tx_tick),
        .wrap  (tx_wrap_unused)
    );

    // Restarting on the RX wrap lets the last sub-interval absorb the remainder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovs_cnt  <= '0;
            ovs_tick <= 1'b0;
        end else begin
            ovs_tick <= rx_en && !cfg_err && (ovs_cnt == odiv_sel);
            if (!rx_en || rx_wrap || (ovs_cnt == odiv_sel)) begin
                ovs_cnt <= '0;
            end else begin
                ovs_cnt <= ovs_cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_baud_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_baud_gen : bench for uart_baud_gen against a bit-period model     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_uart_baud_gen;

    localparam int CLK_HZ = 50_000_000;
    localparam int OVS    = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] baud_sel;
    logic       rx_en, tx_en;
    logic       rx_mid, ovs_tick, tx_tick, busy, cfg_err;
    logic [2:0] active_sel;

    logic [2:0] b_sel;
    logic       b_rx_en;
    logic       b_rx_mid_unused, b_ovs, b_tx_unused, b_busy, b_cfg_err;
    logic [2:0] b_active;

    always #5 clk = ~clk;

    uart_baud_gen #(.CLK_HZ(CLK_HZ), .CNT_W(16), .OVS(OVS)) dut (
        .clk(clk), .rst_n(rst_n), .baud_sel(baud_sel), .rx_en(rx_en), .tx_en(tx_en),
        .rx_mid(rx_mid), .ovs_tick(ovs_tick), .tx_tick(tx_tick),
        .active_sel(active_sel), .busy(busy), .cfg_err(cfg_err)
    );

    uart_baud_gen #(.CLK_HZ(200_000), .CNT_W(16), .OVS(OVS)) dut_slow (
        .clk(clk), .rst_n(rst_n), .baud_sel(b_sel), .rx_en(b_rx_en), .tx_en(1'b0),
        .rx_mid(b_rx_mid_unused), .ovs_tick(b_ovs), .tx_tick(b_tx_unused),
        .active_sel(b_active), .busy(b_busy), .cfg_err(b_cfg_err)
    );

    int bauds [8] = '{9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600};

    int checks   = 0;
    int failures = 0;

    // Reference state: how many consecutive enabled edges each channel has seen.
    int   rx_age = -1;
    int   tx_age = -1;
    int   m_sel  = 0;
    logic m_busy = 1'b0;
    int   e_rx = 0, e_ovs = 0, e_tx = 0, e_misc = 0;
    int   q_rx[$], q_ovs[$], q_tx[$];
    int   n_bovs = 0;

    function automatic int ref_div(input int clk_hz, input int k);
        return $rtoi($floor(real'(clk_hz) / real'(bauds[k]) + 0.5)) - 1;
    endfunction

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic check(input string tag, input int obs, input int want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, want);
        end
    endtask

    task automatic step();
        int   d, p, o, pos;
        logic er, ex_rx, ex_tx, ex_ovs;
        if (rx_en) rx_age++; else rx_age = -1;
        if (tx_en) tx_age++; else tx_age = -1;
        if (!rx_en && !tx_en) m_sel = int'(baud_sel);
        m_busy = rx_en | tx_en;
        @(posedge clk);
        #1;
        d      = ref_div(CLK_HZ, m_sel);
        p      = d + 1;
        o      = p / OVS - 1;
        er     = (p < OVS);
        ex_rx  = (rx_age >= 0) && (rx_age % p == d / 2);
        ex_tx  = (tx_age >= 0) && (tx_age % p == d);
        ex_ovs = 1'b0;
        if (!er && rx_age >= 0) begin
            pos    = rx_age % p;
            ex_ovs = (pos % (o + 1) == o);
        end
        if (rx_mid !== ex_rx) e_rx++;
        if (tx_tick !== ex_tx) e_tx++;
        if (m_sel <= 5 && ovs_tick !== ex_ovs) e_ovs++;
        if (active_sel !== 3'(m_sel) || busy !== m_busy || cfg_err !== er) e_misc++;
        if (rx_mid === 1'b1) q_rx.push_back(rx_age);
        if (ovs_tick === 1'b1) q_ovs.push_back(rx_age);
        if (tx_tick === 1'b1) q_tx.push_back(tx_age);
        if (b_ovs === 1'b1) n_bovs++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic open_win();
        q_rx.delete();
        q_ovs.delete();
        q_tx.delete();
    endtask

    task automatic close_win(input string tag);
        check({tag, " rx_mid cycle errors"}, e_rx, 0);
        check({tag, " ovs_tick cycle errors"}, e_ovs, 0);
        check({tag, " tx_tick cycle errors"}, e_tx, 0);
        check({tag, " sel/busy/cfg_err cycle errors"}, e_misc, 0);
        e_rx = 0; e_ovs = 0; e_tx = 0; e_misc = 0;
    endtask

    initial begin
        int n;
        int cnt_first;
        rst_n = 1'b0; baud_sel = 3'd0; rx_en = 1'b0; tx_en = 1'b0;
        b_sel = 3'd0; b_rx_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset rx_mid", int'(rx_mid), 0);
        check("reset ovs_tick", int'(ovs_tick), 0);
        check("reset tx_tick", int'(tx_tick), 0);
        check("reset busy", int'(busy), 0);
        check("reset cfg_err", int'(cfg_err), 0);
        check("reset active_sel", int'(active_sel), 0);
        rst_n = 1'b1;

        // Slow RX at 9600: mid-bit strobe timing.
        baud_sel = 3'd0; step();
        open_win(); rx_en = 1'b1; run(7816);
        check("t1 rx_mid count", q_rx.size(), 2);
        check("t1 first rx_mid edge", qat(q_rx, 0), 2603);
        check("t1 rx_mid period", qat(q_rx, 1) - qat(q_rx, 0), 5208);
        check("t1 tx_tick count", q_tx.size(), 0);
        close_win("t1");

        // Rate change while busy is ignored, applied on the first idle edge.
        baud_sel = 3'd7;
        open_win(); run(5208);
        check("t4 rx_mid count held", q_rx.size(), 1);
        check("t4 rx_mid edge held", qat(q_rx, 0), 2603 + 2 * 5208);
        check("t4 active_sel held", int'(active_sel), 0);
        rx_en = 1'b0; step();
        check("t4 active_sel applied", int'(active_sel), 7);
        open_win(); rx_en = 1'b1; run(200);
        check("t4 first rx_mid at 921600", qat(q_rx, 0), 26);
        check("t4 rx_mid period at 921600", qat(q_rx, 1) - qat(q_rx, 0), 54);
        rx_en = 1'b0; baud_sel = 3'd4; step();
        close_win("t4");

        // TX end-of-bit ticks at 115200.
        open_win(); tx_en = 1'b1; run(1302);
        check("t2 tx_tick count", q_tx.size(), 3);
        check("t2 tx_tick 0", qat(q_tx, 0), 433);
        check("t2 tx_tick 1", qat(q_tx, 1), 867);
        check("t2 tx_tick 2", qat(q_tx, 2), 1301);
        check("t2 active_sel", int'(active_sel), 4);
        tx_en = 1'b0; step();
        close_win("t2");

        // Oversample ticks at 115200 over two bit periods.
        open_win(); rx_en = 1'b1; run(868);
        cnt_first = 0;
        foreach (q_ovs[i]) if (q_ovs[i] < 434) cnt_first++;
        check("t3 ovs ticks in first bit", cnt_first, 16);
        check("t3 ovs ticks in two bits", q_ovs.size(), 32);
        check("t3 first ovs edge", qat(q_ovs, 0), 26);
        check("t3 ovs spacing", qat(q_ovs, 1) - qat(q_ovs, 0), 27);
        check("t3 ovs final gap", qat(q_ovs, 16) - qat(q_ovs, 15), 29);
        rx_en = 1'b0; step();
        close_win("t3");

        // Enable dropped mid-bit, then re-raised: realign to new start bit.
        baud_sel = 3'd0; step();
        open_win(); rx_en = 1'b1; run(1000);
        rx_en = 1'b0; run(5);
        rx_en = 1'b1; run(2610);
        check("t5 rx_mid count", q_rx.size(), 1);
        check("t5 rx_mid after realign", qat(q_rx, 0), 2603);
        rx_en = 1'b0; step();
        close_win("t5");

        // Randomised enables and rate requests against the reference model.
        for (int it = 0; it < 6; it++) begin
            rx_en = 1'b0; tx_en = 1'b0;
            baud_sel = 3'($urandom_range(2, 7));
            step();
            open_win();
            rx_en = 1'($urandom_range(0, 1));
            tx_en = 1'($urandom_range(0, 1));
            if (!rx_en && !tx_en) rx_en = 1'b1;
            n = $urandom_range(300, 1400);
            for (int c = 0; c < n; c++) begin
                if ($urandom_range(0, 199) == 0) rx_en = ~rx_en;
                if ($urandom_range(0, 199) == 0) tx_en = ~tx_en;
                if ($urandom_range(0, 99) == 0) baud_sel = 3'($urandom);
                step();
            end
            close_win("rand");
        end

        // Asynchronous reset with both channels running.
        rx_en = 1'b0; tx_en = 1'b0; baud_sel = 3'd4; step();
        rx_en = 1'b1; tx_en = 1'b1; run(300);
        close_win("t6 pre");
        check("t6 active_sel before reset", int'(active_sel), 4);
        check("t6 busy before reset", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("t6 rx_mid in reset", int'(rx_mid), 0);
        check("t6 ovs_tick in reset", int'(ovs_tick), 0);
        check("t6 tx_tick in reset", int'(tx_tick), 0);
        check("t6 busy in reset", int'(busy), 0);
        check("t6 active_sel in reset", int'(active_sel), 0);
        rx_en = 1'b0; tx_en = 1'b0; baud_sel = 3'd0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rx_age = -1; tx_age = -1; m_sel = 0; m_busy = 1'b0;

        // 200 kHz clock: 921600 cannot be oversampled.
        step();
        check("slow cfg_err at 9600", int'(b_cfg_err), 0);
        b_sel = 3'd7; step();
        check("slow active_sel", int'(b_active), 7);
        check("slow cfg_err at 921600", int'(b_cfg_err), 1);
        b_rx_en = 1'b1; n_bovs = 0; run(100);
        check("slow ovs_tick count", n_bovs, 0);
        check("slow busy", int'(b_busy), 1);
        close_win("tail");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
